router_out_arbiter: RTL and testbench



---
 rtl/router_out_arbiter_if.sv | 34 +++
 rtl/router_out_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_router_out_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_out_arbiter_if.sv
// router_out_arbiter_if
//   Bundles the three FIFO read ports and the downstream byte stream of the
//   router output arbiter.
//   master : arbiter side (drives pops, flushes and the output stream)
//   slave  : FIFO / sink side
//   FIFO ports : empty_x, dout_x (in to master); read_enb_x, soft_reset_x (out)
//   Stream     : out_data, out_valid, out_sop, out_eop, out_port, out_abort,
//                parity_err, busy (out of master); out_ready (in to master)
interface router_out_arbiter_if;
  logic       empty_0, empty_1, empty_2;
  logic [7:0] dout_0, dout_1, dout_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_sop, out_eop;
  logic [1:0] out_port;
  logic       out_abort, parity_err, busy;

  modport master (
    input  empty_0, empty_1, empty_2, dout_0, dout_1, dout_2, out_ready,
    output read_enb_0, read_enb_1, read_enb_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           out_data, out_valid, out_sop, out_eop, out_port,
           out_abort, parity_err, busy
  );

  modport slave (
    output empty_0, empty_1, empty_2, dout_0, dout_1, dout_2, out_ready,
    input  read_enb_0, read_enb_1, read_enb_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           out_data, out_valid, out_sop, out_eop, out_port,
           out_abort, parity_err, busy
  );
endinterface

// File: rtl/router_out_arbiter.sv
// router_out_arbiter
//   Output-side scheduler of the 1x3 router. Grants one of three FIFOs per
//   whole packet in round-robin order, reads the header to learn the payload
//   length and drains header + payload + parity through a 2-entry skid buffer.
//   A packet whose FIFO stays empty for TIMEOUT_CYCLES mid-packet is aborted
//   by pulsing that FIFO's soft reset.
//   Ports : clk, reset (async, active high), bus (router_out_arbiter_if.master)
//   Option: define ROUTER_OUT_ARB_PARITY_CHECK_EN to check the parity byte
//           against a running XOR of header + payload (parity_err pulse).
module router_out_arbiter #(
  parameter int TIMEOUT_CYCLES = 30,
  parameter int TO_W           = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  router_out_arbiter_if.master bus
);
  localparam int NUM_PORTS = 3;

  typedef enum logic [2:0] {IDLE, HDR, LEN, BODY, DONE, ABORT} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } ent_t;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [NUM_PORTS-1:0]      empty_v, rd_v, sr_v;
  logic [NUM_PORTS-1:0][7:0] dout_v;

  assign empty_v = {bus.empty_2, bus.empty_1, bus.empty_0};
  assign dout_v  = {bus.dout_2, bus.dout_1, bus.dout_0};

  state_t          state, state_nx;
  logic [1:0]      grant, grant_nx, rr_ptr, p1, p2;
  logic            any_req;
  logic [6:0]      bytes_left, bl_eff;
  logic [TO_W-1:0] stall_cnt;
  logic            to_hit;
  logic            inflight, infl_sop, infl_eop;
  ent_t            buf_q [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      cnt;
  ent_t            head;
  logic            out_valid, push, pop, rd, space_ok, src_empty, eop_xfer;
  logic            reading, abort_o;
  logic [7:0]      src_data;

  assign src_empty = empty_v[grant];
  assign src_data  = dout_v[grant];
  assign to_hit    = (stall_cnt == TO_W'(TIMEOUT_CYCLES));

  // Round-robin search rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3)
  always_comb begin
    p1      = inc3(rr_ptr);
    p2      = inc3(p1);
    any_req = ~&empty_v;
    if (!empty_v[rr_ptr])  grant_nx = rr_ptr;
    else if (!empty_v[p1]) grant_nx = p1;
    else                   grant_nx = p2;
  end

  // Bytes still to read: HDR needs just the header; in LEN the header is on
  // dout right now, so its length is used directly to keep reads back-to-back.
  always_comb begin
    case (state)
      HDR:     bl_eff = 7'd1;
      LEN:     bl_eff = {1'b0, src_data[7:2]} + 7'd1;
      default: bl_eff = bytes_left;
    endcase
  end

  // Occupancy credit counts the head leaving this cycle, otherwise a full
  // pipeline (1 buffered + 1 in flight) would stall every other cycle.
  assign space_ok = ({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
  assign reading  = (state == HDR) || (state == LEN) || (state == BODY);
  assign rd       = reading && !src_empty && (bl_eff != 7'd0) && space_ok && !to_hit;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (any_req) state_nx = HDR;
      HDR:   if (rd) state_nx = LEN;
      LEN:   state_nx = BODY;
      BODY: begin
        if (bytes_left == 7'd0) state_nx = DONE;
        else if (to_hit)        state_nx = ABORT;
      end
      DONE:  if (eop_xfer) state_nx = IDLE;
      ABORT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rd_v    = '0;
    sr_v    = '0;
    abort_o = 1'b0;
    if (rd) rd_v[grant] = 1'b1;
    if (state == ABORT) begin
      sr_v[grant] = 1'b1;
      abort_o     = 1'b1;
    end
  end

  // Grant, pointer, length and stall bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= 2'd0;
      rr_ptr     <= 2'd0;
      bytes_left <= 7'd0;
      stall_cnt  <= '0;
      inflight   <= 1'b0;
      infl_sop   <= 1'b0;
      infl_eop   <= 1'b0;
    end else begin
      if (state == IDLE && any_req) grant <= grant_nx;
      if ((state == DONE && eop_xfer) || state == ABORT) rr_ptr <= inc3(grant);
      if (state == LEN)             bytes_left <= bl_eff - {6'd0, rd};
      else if (state == BODY && rd) bytes_left <= bytes_left - 7'd1;
      if (state != BODY || rd)
        stall_cnt <= '0;
      else if (src_empty && bytes_left != 7'd0 && !to_hit)
        stall_cnt <= stall_cnt + 1'b1;
      inflight <= rd;
      infl_sop <= rd && (state == HDR);
      infl_eop <= rd && (state != HDR) && (bl_eff == 7'd1);
    end
  end

  // 2-entry skid buffer; the byte read last cycle is on dout now
  assign push      = inflight;
  assign head      = buf_q[rd_ptr];
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  assign eop_xfer  = pop && head.eop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= ent_t'{data: src_data, sop: infl_sop, eop: infl_eop, port: grant};
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef ROUTER_OUT_ARB_PARITY_CHECK_EN
  // Running XOR restarts on each header; the parity byte itself is excluded.
  // The next packet cannot enter before the eop leaves, so xor_q is stable
  // when the parity byte is compared.
  logic [7:0] xor_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   xor_q <= 8'h00;
    else if (push && !infl_eop)  xor_q <= infl_sop ? src_data : (xor_q ^ src_data);
  end
  assign bus.parity_err = eop_xfer && (head.data != xor_q);
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.read_enb_0   = rd_v[0];
  assign bus.read_enb_1   = rd_v[1];
  assign bus.read_enb_2   = rd_v[2];
  assign bus.soft_reset_0 = sr_v[0];
  assign bus.soft_reset_1 = sr_v[1];
  assign bus.soft_reset_2 = sr_v[2];
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_valid ? head.data : 8'h00;
  assign bus.out_sop      = out_valid && head.sop;
  assign bus.out_eop      = out_valid && head.eop;
  assign bus.out_port     = abort_o ? grant : (out_valid ? head.port : 2'd0);
  assign bus.out_abort    = abort_o;
  assign bus.busy         = (state != IDLE) || out_valid;
endmodule

// File: tb/tb_router_out_arbiter.sv
// tb_router_out_arbiter
//   Directed bench for router_out_arbiter. Behavioural FIFO models feed the
//   arbiter; expected stream bytes are queued when a packet is loaded and
//   compared as each byte transfers.
module tb_router_out_arbiter;
  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } exp_t;

  logic clk, reset;
  router_out_arbiter_if bif();

  router_out_arbiter #(.TIMEOUT_CYCLES(30), .TO_W(6)) dut (
    .clk(clk), .reset(reset), .bus(bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] q0[$], q1[$], q2[$];
  exp_t       exp_q[$];

  int checks, errors, cyc;
  int rd_total, rd1_total, run1, run1_max, xfer_total, first_xfer, last_xfer;
  int eop_cnt, eop_cyc, abort_cnt, abort_port, perr_cnt, perr_eop_cnt, hold_cnt;
  int sr_cnt[3];
  bit hold_pend, chk_out;
  logic [7:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ctl();
    return {bif.read_enb_2, bif.read_enb_1, bif.read_enb_0,
            bif.soft_reset_2, bif.soft_reset_1, bif.soft_reset_0,
            bif.out_valid, bif.out_sop, bif.out_eop, bif.out_abort,
            bif.parity_err, bif.busy};
  endfunction

  task automatic upd_empty();
    bif.empty_0 = (q0.size() == 0);
    bif.empty_1 = (q1.size() == 0);
    bif.empty_2 = (q2.size() == 0);
  endtask

  task automatic push_fifo(input int port, input logic [7:0] b);
    case (port)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  // Header {len, port}; payload byte i = seed*(i+1); parity = XOR of header
  // and payload (or 00 when bad_par). The parity byte is only written when
  // the full payload is present.
  task automatic load_pkt(input int port, input int len, input int n_pay,
                          input logic [7:0] seed, input bit bad_par);
    logic [7:0] hdr, b, par;
    logic [1:0] pp;
    pp  = 2'(port);
    hdr = {6'(len), pp};
    par = hdr;
    push_fifo(port, hdr);
    exp_q.push_back(exp_t'{data: hdr, sop: 1'b1, eop: 1'b0, port: pp});
    for (int i = 0; i < n_pay; i++) begin
      b   = 8'(int'(seed) * (i + 1));
      par = par ^ b;
      push_fifo(port, b);
      exp_q.push_back(exp_t'{data: b, sop: 1'b0, eop: 1'b0, port: pp});
    end
    if (n_pay == len) begin
      if (bad_par) par = 8'h00;
      push_fifo(port, par);
      exp_q.push_back(exp_t'{data: par, sop: 1'b0, eop: 1'b1, port: pp});
    end
    upd_empty();
  endtask

  task automatic clear_stats();
    rd_total = 0; rd1_total = 0; run1 = 0; run1_max = 0;
    xfer_total = 0; first_xfer = -1; last_xfer = -1;
    eop_cnt = 0; eop_cyc = -1; abort_cnt = 0; abort_port = -1;
    perr_cnt = 0; perr_eop_cnt = 0; hold_cnt = 0; hold_pend = 1'b0;
    for (int i = 0; i < 3; i++) sr_cnt[i] = 0;
  endtask

  // One clock: drive out_ready, sample just after the falling edge, then let
  // the FIFO models react to the pops/flushes seen at the rising edge.
  task automatic step(input logic rdy);
    logic [2:0] re, sr;
    exp_t e;
    bit xfer;
    bif.out_ready = rdy;
    #1;
    re   = {bif.read_enb_2, bif.read_enb_1, bif.read_enb_0};
    sr   = {bif.soft_reset_2, bif.soft_reset_1, bif.soft_reset_0};
    xfer = bif.out_valid && bif.out_ready;
    rd_total += $countones(re);
    if (re[1]) begin
      rd1_total++;
      run1++;
      if (run1 > run1_max) run1_max = run1;
    end else run1 = 0;
    if (hold_pend) begin
      hold_cnt++;
      chk("hold_valid", 32'(bif.out_valid), 1);
      chk("hold_data", 32'(bif.out_data), 32'(held));
    end
    hold_pend = bif.out_valid && !bif.out_ready;
    held      = bif.out_data;
    if (xfer) begin
      xfer_total++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      if (bif.out_eop) begin eop_cnt++; eop_cyc = cyc; end
      if (exp_q.size() == 0) chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(bif.out_data), 32'(e.data));
        chk("out_sop", 32'(bif.out_sop), 32'(e.sop));
        chk("out_eop", 32'(bif.out_eop), 32'(e.eop));
        chk("out_port", 32'(bif.out_port), 32'(e.port));
      end
    end
    if (bif.out_abort) begin abort_cnt++; abort_port = int'(bif.out_port); end
    for (int i = 0; i < 3; i++) if (sr[i]) sr_cnt[i]++;
    if (bif.parity_err) begin
      perr_cnt++;
      if (xfer && bif.out_eop) perr_eop_cnt++;
    end
    if (chk_out) chk("outstanding", 32'((rd_total - xfer_total) <= 2), 1);
    @(posedge clk);
    #1;
    if (re[0] && q0.size() != 0) bif.dout_0 = q0.pop_front();
    if (re[1] && q1.size() != 0) bif.dout_1 = q1.pop_front();
    if (re[2] && q2.size() != 0) bif.dout_2 = q2.pop_front();
    if (sr[0]) q0.delete();
    if (sr[1]) q1.delete();
    if (sr[2]) q2.delete();
    upd_empty();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_idle(input int bound, input string tag);
    int n;
    n = 0;
    while (n < bound && (exp_q.size() != 0 || bif.busy)) begin
      step(1'b1);
      n++;
    end
    chk({tag, "_idle"}, 32'(bif.busy), 0);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; chk_out = 1'b0; held = 8'h00;
    clear_stats();
    reset = 1'b1;
    bif.out_ready = 1'b0;
    bif.dout_0 = 8'h00; bif.dout_1 = 8'h00; bif.dout_2 = 8'h00;
    upd_empty();

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_ctl", 32'(ctl()), 0);
    chk("rst_data", 32'(bif.out_data), 0);
    chk("rst_port", 32'(bif.out_port), 0);
    @(negedge clk);
    reset = 1'b0;

    // T1: FIFO1 0D,11,22,33,parity(0D) back-to-back
    clear_stats();
    load_pkt(1, 3, 3, 8'h11, 1'b0);
    run_idle(40, "t1");
    chk("t1_rd1_total", rd1_total, 5);
    chk("t1_rd1_run", run1_max, 5);
    chk("t1_xfers", xfer_total, 5);
    chk("t1_xfer_span", last_xfer - first_xfer, 4);
    chk("t1_busy_fall", cyc - eop_cyc, 1);

    // T5: reset in BODY on port 0 (rr_ptr is 2 here), then grant restarts from 0
    clear_stats();
    load_pkt(0, 10, 10, 8'h05, 1'b0);
    repeat (8) step(1'b1);
    chk("t5_busy_pre", 32'(bif.busy), 1);
    chk("t5_valid_pre", 32'(bif.out_valid), 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_ctl", 32'(ctl()), 0);
    chk("t5_rst_data", 32'(bif.out_data), 0);
    chk("t5_rst_port", 32'(bif.out_port), 0);
    q0.delete(); q1.delete(); q2.delete();
    exp_q.delete();
    upd_empty();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    load_pkt(1, 0, 0, 8'h00, 1'b0);
    load_pkt(2, 0, 0, 8'h00, 1'b0);
    run_idle(40, "t5");

    // T2: all three L=0 -> 0,1,2; then 2 and 0 pending -> 0 first
    clear_stats();
    load_pkt(0, 0, 0, 8'h00, 1'b0);
    load_pkt(1, 0, 0, 8'h00, 1'b0);
    load_pkt(2, 0, 0, 8'h00, 1'b0);
    run_idle(60, "t2a");
    chk("t2a_eops", eop_cnt, 3);
    load_pkt(0, 0, 0, 8'h00, 1'b0);
    load_pkt(2, 0, 0, 8'h00, 1'b0);
    run_idle(40, "t2b");

    // T3: 6-byte packet, out_ready pattern 1,0,0,1
    clear_stats();
    chk_out = 1'b1;
    load_pkt(0, 4, 4, 8'h21, 1'b0);
    for (int i = 0; i < 80 && (exp_q.size() != 0 || bif.busy); i++)
      step(((i % 4) == 0) || ((i % 4) == 3));
    chk_out = 1'b0;
    chk("t3_idle", 32'(bif.busy), 0);
    chk("t3_sb_empty", 32'(exp_q.size()), 0);
    chk("t3_xfers", xfer_total, 6);
    chk("t3_reads", rd_total, 6);
    chk("t3_holds_seen", 32'(hold_cnt > 0), 1);

    // T6: parity check on FIFO1 (bad parity 00, then the correct 0D)
    clear_stats();
    load_pkt(1, 3, 3, 8'h11, 1'b1);
    run_idle(40, "t6a");
`ifdef ROUTER_OUT_ARB_PARITY_CHECK_EN
    chk("t6_perr_bad", perr_cnt, 1);
    chk("t6_perr_on_eop", perr_eop_cnt, 1);
`else
    chk("t6_perr_off", perr_cnt, 0);
`endif
    clear_stats();
    load_pkt(1, 3, 3, 8'h11, 1'b0);
    run_idle(40, "t6b");
    chk("t6_perr_good", perr_cnt, 0);

    // T4: FIFO2 header L=5 with only 2 payload bytes -> abort
    clear_stats();
    load_pkt(2, 5, 2, 8'h31, 1'b0);
    run_idle(200, "t4");
    chk("t4_abort_cnt", abort_cnt, 1);
    chk("t4_abort_port", abort_port, 2);
    chk("t4_sr2", sr_cnt[2], 1);
    chk("t4_sr01", sr_cnt[0] + sr_cnt[1], 0);
    chk("t4_xfers", xfer_total, 3);
    chk("t4_no_eop", eop_cnt, 0);
    load_pkt(0, 0, 0, 8'h00, 1'b0);
    load_pkt(2, 0, 0, 8'h00, 1'b0);
    run_idle(40, "t4b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
